// File: rtl/col16x_clock_supervisor.sv
// MMCM reset sequencer and 16x colour-carrier frequency checker in the 12 MHz domain.
// Holds the MMCM in reset, waits for lock, measures the returned toggle, then supervises continuously.
module col16x_clock_supervisor #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 12000,
    parameter int unsigned WINDOW       = 1200,
    parameter int unsigned EXP_MIN      = 176,
    parameter int unsigned EXP_MAX      = 182,
    parameter int unsigned MAX_RETRIES  = 7
) (
    input  logic        clk_in12mhz,
    input  logic        reset_n,
    input  logic        mmcm_locked,
    input  logic        col16x_tog,
    output logic        mmcm_reset,
    output logic        clk_ok,
    output logic [2:0]  retry_count,
    output logic [10:0] last_count,
    output logic        fail
);

    localparam int unsigned CNT_MAX =
        (LOCK_TIMEOUT > WINDOW) ? ((LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES)
                                : ((WINDOW > RST_CYCLES) ? WINDOW : RST_CYCLES);
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        HOLD,
        WAIT_LOCK,
        CHECK,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic             lock_m, lock_s;
    logic             tog_m, tog_s, tog_h;
    logic             tog_edge;
    logic [CNT_W-1:0] cnt;
    logic [10:0]      ecnt, ecnt_next;
    logic [2:0]       retry_inc;
    logic             measuring, win_end, in_range;
    logic             restart, clr;

    always_ff @(posedge clk_in12mhz or negedge reset_n) begin
        if (!reset_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            tog_m  <= 1'b0;
            tog_s  <= 1'b0;
            tog_h  <= 1'b0;
        end else begin
            lock_m <= mmcm_locked;
            lock_s <= lock_m;
            tog_m  <= col16x_tog;
            tog_s  <= tog_m;
            tog_h  <= tog_s;
        end
    end

    assign tog_edge  = tog_s ^ tog_h;
    assign measuring = (state == CHECK) || (state == RUN);
    assign win_end   = measuring && (cnt == CNT_W'(WINDOW - 1));
    // Window total includes an edge arriving in the window's final cycle.
    assign ecnt_next = (tog_edge && (ecnt != '1)) ? ecnt + 11'd1 : ecnt;
    assign in_range  = (ecnt_next >= 11'(EXP_MIN)) && (ecnt_next <= 11'(EXP_MAX));
    assign retry_inc = (retry_count == 3'd7) ? retry_count : retry_count + 3'd1;

    always_comb begin
        state_nxt  = state;
        restart    = 1'b0;
        clr        = 1'b0;
        mmcm_reset = (state == HOLD);
        clk_ok     = (state == RUN);
        case (state)
            HOLD: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_nxt = WAIT_LOCK;
                    clr       = 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = CHECK;
                    clr       = 1'b1;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    restart = 1'b1;
                end
            end
            CHECK, RUN: begin
                // Lock loss takes priority over a window verdict in the same cycle.
                if (!lock_s) begin
                    restart = 1'b1;
                end else if (win_end) begin
                    if (in_range) begin
                        state_nxt = RUN;
                        clr       = 1'b1;
                    end else begin
                        restart = 1'b1;
                    end
                end
            end
            default: state_nxt = HOLD;
        endcase
        if (restart) state_nxt = HOLD;
    end

    always_ff @(posedge clk_in12mhz or negedge reset_n) begin
        if (!reset_n) state <= HOLD;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk_in12mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            ecnt        <= '0;
            last_count  <= '0;
            retry_count <= '0;
            fail        <= 1'b0;
        end else begin
            if (restart || clr) begin
                cnt  <= '0;
                ecnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (measuring) ecnt <= ecnt_next;
            end
            if (win_end) last_count <= ecnt_next;
            if (restart) begin
                retry_count <= retry_inc;
                if (32'(retry_inc) >= MAX_RETRIES) fail <= 1'b1;
            end else if (state_nxt == RUN) begin
                retry_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_col16x_clock_supervisor.sv
// Directed bench for col16x_clock_supervisor: sequencing, frequency windows, retries and resets.
`timescale 1ns/1ps
module tb_col16x_clock_supervisor;

    localparam int RST = 16;
    localparam int TO  = 300;
    localparam int WIN = 1200;

    logic        clk_in12mhz;
    logic        reset_n;
    logic        mmcm_locked;
    logic        col16x_tog;
    logic        mmcm_reset;
    logic        clk_ok;
    logic [2:0]  retry_count;
    logic [10:0] last_count;
    logic        fail;

    logic tog_nom, tog_acc, use_nom;
    int   rate;
    int   acc;
    int   n_vec, n_bad;

    col16x_clock_supervisor #(
        .RST_CYCLES  (RST),
        .LOCK_TIMEOUT(TO),
        .WINDOW      (WIN),
        .EXP_MIN     (176),
        .EXP_MAX     (182),
        .MAX_RETRIES (7)
    ) dut (
        .clk_in12mhz(clk_in12mhz),
        .reset_n    (reset_n),
        .mmcm_locked(mmcm_locked),
        .col16x_tog (col16x_tog),
        .mmcm_reset (mmcm_reset),
        .clk_ok     (clk_ok),
        .retry_count(retry_count),
        .last_count (last_count),
        .fail       (fail)
    );

    assign col16x_tog = use_nom ? tog_nom : tog_acc;

    initial begin
        clk_in12mhz = 1'b0;
        forever #41.6667 clk_in12mhz = ~clk_in12mhz;
    end

    // Nominal carrier: 32 cycles of 57.2727 MHz per toggle transition.
    initial begin
        tog_nom = 1'b0;
        forever #558.730 tog_nom = ~tog_nom;
    end

    // Fractional accumulator: exactly 'rate' transitions in any WIN consecutive cycles.
    initial begin
        tog_acc = 1'b0;
        acc     = 0;
        forever begin
            @(negedge clk_in12mhz);
            if (rate != 0) begin
                acc = acc + rate;
                if (acc >= WIN) begin
                    acc     = acc - WIN;
                    tog_acc = ~tog_acc;
                end
            end
        end
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_vec(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in12mhz);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_vec({tag, "_mmcm_reset"}, mmcm_reset, 1);
        check_vec({tag, "_clk_ok"}, clk_ok, 0);
        check_vec({tag, "_retry"}, retry_count, 0);
        check_vec({tag, "_last"}, last_count, 0);
        check_vec({tag, "_fail"}, fail, 0);
    endtask

    int n;
    bit seen_low;
    int tbl_rate [5] = '{143, 175, 176, 182, 183};
    int tbl_pass [5] = '{0, 0, 1, 1, 0};

    initial begin
        n_vec = 0; n_bad = 0;
        reset_n = 1'b0; mmcm_locked = 1'b0; use_nom = 1'b1; rate = 0;
        #200;
        check_reset_vals("por");

        // Power-up sequence with nominal carrier
        @(negedge clk_in12mhz) reset_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (mmcm_reset && n < 100);
        check_vec("hold_len", n, RST);
        repeat (50) @(negedge clk_in12mhz);
        mmcm_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!clk_ok && n < 3000);
        check_vec("lock_to_ok", n, 3 + WIN);
        check_vec("nom_count", int'(last_count == 11'd178 || last_count == 11'd179), 1);
        check_vec("nom_retry", retry_count, 0);

        // Lock drop in RUN and recovery
        repeat (2500) tick();
        check_vec("run_stays", clk_ok, 1);
        @(negedge clk_in12mhz) mmcm_locked = 1'b0;
        n = 0;
        do begin tick(); n++; end while (clk_ok && n < 20);
        check_vec("drop_lat", int'(n <= 3), 1);
        check_vec("drop_rst", mmcm_reset, 1);
        check_vec("drop_retry", retry_count, 1);
        repeat (9) @(negedge clk_in12mhz);
        mmcm_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!clk_ok && n < 3000);
        check_vec("relock_ok", clk_ok, 1);
        check_vec("relock_retry", retry_count, 0);
        check_vec("relock_fail", fail, 0);

        // Persistent lock loss: retries saturate, fail becomes sticky
        @(negedge clk_in12mhz) mmcm_locked = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n = 0; seen_low = 1'b0;
            do begin
                tick(); n++;
                if (!mmcm_reset) seen_low = 1'b1;
            end while (!(seen_low && mmcm_reset) && n < 2 * (RST + TO));
            if (k >= 2) check_vec($sformatf("period_%0d", k), n, RST + TO);
            check_vec($sformatf("retry_%0d", k), retry_count, (k < 7) ? k : 7);
            check_vec($sformatf("fail_%0d", k), fail, (k >= 7) ? 1 : 0);
        end
        @(negedge clk_in12mhz) mmcm_locked = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!clk_ok && n < 3000);
        check_vec("late_ok", clk_ok, 1);
        check_vec("late_retry", retry_count, 0);
        check_vec("late_fail", fail, 1);

        // Asynchronous reset mid-RUN
        repeat (100) tick();
        #20 reset_n = 1'b0;
        #1 check_reset_vals("run_rst");

        // Window-count boundaries with exact per-window edge counts
        use_nom = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in12mhz);
            reset_n = 1'b0;
            rate    = tbl_rate[i];
            repeat (2) @(negedge clk_in12mhz);
            reset_n = 1'b1;
            n = 0;
            do begin tick(); n++; end while (mmcm_reset && n < 100);
            n = 0;
            do begin tick(); n++; end while (!clk_ok && !mmcm_reset && n < 3000);
            check_vec($sformatf("win_ok_%0d", tbl_rate[i]), clk_ok, tbl_pass[i]);
            check_vec($sformatf("win_cnt_%0d", tbl_rate[i]), last_count, tbl_rate[i]);
            check_vec($sformatf("win_retry_%0d", tbl_rate[i]), retry_count, tbl_pass[i] ? 0 : 1);
            if (i == 0) begin
                // Asynchronous reset mid-CHECK
                n = 0;
                do begin tick(); n++; end while (mmcm_reset && n < 100);
                repeat (500) tick();
                check_vec("chk_pre_rst", mmcm_reset, 0);
                #20 reset_n = 1'b0;
                #1 check_reset_vals("chk_rst");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
